// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined MIPS datapath.
// Holds the decoded instruction for EX, detects load-use hazards (one bubble,
// PC and IF/ID frozen), squashes the ID instruction on a taken branch, and
// keeps a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [1:0]        id_aluOp,
  input  logic [5:0]        id_func,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_memToReg,
  input  logic              id_aluSrc,
  input  logic              id_regDst,
  input  logic              id_branch,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  output logic              ex_valid,
  output logic [1:0]        ex_aluOp,
  output logic [5:0]        ex_func,
  output logic              ex_regWrite,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic              ex_memToReg,
  output logic              ex_aluSrc,
  output logic              ex_regDst,
  output logic              ex_branch,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_count
);

  // A bubble uses the ADD class so ALU control never decodes a stray funct.
  localparam logic [1:0] ALUOP_BUBBLE = 2'b01;

  logic              valid_q,    valid_d;
  logic [1:0]        aluop_q,    aluop_d;
  logic [5:0]        func_q,     func_d;
  logic [6:0]        ctl_q,      ctl_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [REG_W-1:0]  rs_q,       rs_d;
  logic [REG_W-1:0]  rt_q,       rt_d;
  logic [REG_W-1:0]  rd_q,       rd_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              hz;
  logic              load_bubble;

  // Control bits packed MSB..LSB: regWrite, memRead, memWrite, memToReg,
  // aluSrc, regDst, branch.
  logic [6:0] id_ctl;
  assign id_ctl = {id_regWrite, id_memRead, id_memWrite, id_memToReg,
                   id_aluSrc, id_regDst, id_branch};

  // Load-use detection: a load in EX whose destination feeds either ID source.
  // Both sources are compared even for I-type, which is merely conservative.
  always_comb begin
    hz = valid_q && ctl_q[5] && (rt_q != '0) && id_valid &&
         ((rt_q == id_rs) || (rt_q == id_rt));
  end

  assign stall      = hz & ~flush;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;

  // Next-state selection: reset > flush > hazard > empty ID > load ID.
  always_comb begin
    load_bubble = reset || flush || hz || !id_valid;
    cnt_d       = cnt_q;
    if (reset) begin
      cnt_d = '0;
    end else if (!flush && hz && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    valid_d   = 1'b0;
    aluop_d   = ALUOP_BUBBLE;
    func_d    = '0;
    ctl_d     = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    if (!load_bubble) begin
      valid_d   = 1'b1;
      aluop_d   = id_aluOp;
      func_d    = id_func;
      ctl_d     = id_ctl;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
    end
  end

  // EX register and bubble counter; reset is already folded into the _d terms.
  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    aluop_q   <= aluop_d;
    func_q    <= func_d;
    ctl_q     <= ctl_d;
    rs_data_q <= rs_data_d;
    rt_data_q <= rt_data_d;
    imm_q     <= imm_d;
    rs_q      <= rs_d;
    rt_q      <= rt_d;
    rd_q      <= rd_d;
    cnt_q     <= cnt_d;
  end

  assign ex_valid    = valid_q;
  assign ex_aluOp    = aluop_q;
  assign ex_func     = func_q;
  assign ex_regWrite = ctl_q[6];
  assign ex_memRead  = ctl_q[5];
  assign ex_memWrite = ctl_q[4];
  assign ex_memToReg = ctl_q[3];
  assign ex_aluSrc   = ctl_q[2];
  assign ex_regDst   = ctl_q[1];
  assign ex_branch   = ctl_q[0];
  assign ex_rs_data  = rs_data_q;
  assign ex_rt_data  = rt_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued when each
// step is driven and compared after the following rising edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [6:0]  ctl;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ex_t;

  typedef struct {
    ex_t ex;
    int  cnt;
    int  cnt2;
  } sb_t;

  localparam ex_t BUBBLE = '{v: 1'b0, op: 2'b01, fn: 6'd0, ctl: 7'd0,
                             rsd: 32'd0, rtd: 32'd0, imm: 32'd0,
                             rs: 5'd0, rt: 5'd0, rd: 5'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, id_valid, flush;
  logic [1:0]  id_aluOp;
  logic [5:0]  id_func;
  logic        id_regWrite, id_memRead, id_memWrite, id_memToReg;
  logic        id_aluSrc, id_regDst, id_branch;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;

  logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg;
  logic        ex_aluSrc, ex_regDst, ex_branch;
  logic [1:0]  ex_aluOp;
  logic [5:0]  ex_func;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        stall, pc_write, ifid_write;
  logic [15:0] stall_count;

  logic        ex_valid2, ex_regWrite2, ex_memRead2, ex_memWrite2, ex_memToReg2;
  logic        ex_aluSrc2, ex_regDst2, ex_branch2;
  logic [1:0]  ex_aluOp2;
  logic [5:0]  ex_func2;
  logic [31:0] ex_rs_data2, ex_rt_data2, ex_imm2;
  logic [4:0]  ex_rs2, ex_rt2, ex_rd2;
  logic        stall2, pc_write2, ifid_write2;
  logic [1:0]  stall_count2;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_aluOp(id_aluOp),
    .id_func(id_func), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .id_memWrite(id_memWrite), .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc),
    .id_regDst(id_regDst), .id_branch(id_branch), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .ex_valid(ex_valid), .ex_aluOp(ex_aluOp),
    .ex_func(ex_func), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc),
    .ex_regDst(ex_regDst), .ex_branch(ex_branch), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_aluOp(id_aluOp),
    .id_func(id_func), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .id_memWrite(id_memWrite), .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc),
    .id_regDst(id_regDst), .id_branch(id_branch), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .ex_valid(ex_valid2), .ex_aluOp(ex_aluOp2),
    .ex_func(ex_func2), .ex_regWrite(ex_regWrite2), .ex_memRead(ex_memRead2),
    .ex_memWrite(ex_memWrite2), .ex_memToReg(ex_memToReg2), .ex_aluSrc(ex_aluSrc2),
    .ex_regDst(ex_regDst2), .ex_branch(ex_branch2), .ex_rs_data(ex_rs_data2),
    .ex_rt_data(ex_rt_data2), .ex_imm(ex_imm2), .ex_rs(ex_rs2), .ex_rt(ex_rt2),
    .ex_rd(ex_rd2), .stall(stall2), .pc_write(pc_write2), .ifid_write(ifid_write2),
    .stall_count(stall_count2)
  );

  ex_t obs_ex;
  assign obs_ex = '{v: ex_valid, op: ex_aluOp, fn: ex_func,
                    ctl: {ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg,
                          ex_aluSrc, ex_regDst, ex_branch},
                    rsd: ex_rs_data, rtd: ex_rt_data, imm: ex_imm,
                    rs: ex_rs, rt: ex_rt, rd: ex_rd};

  int  checks = 0;
  int  errors = 0;
  sb_t sbq[$];
  ex_t m_ex;
  int  m_cnt;
  int  m_cnt2;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one ID-side step, check the combinational hazard outputs against the
  // reference EX state, queue the expected register contents, then compare
  // them after the rising edge.
  task automatic step(input string tag, input logic rst, input logic fl,
                      input logic v, input logic [1:0] op, input logic [5:0] fn,
                      input logic [6:0] ctl, input logic [31:0] rsd,
                      input logic [31:0] rtd, input logic [31:0] imm,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    logic hz;
    logic exp_stall;
    sb_t  e;
    sb_t  got;
    @(negedge clk);
    reset = rst; flush = fl; id_valid = v; id_aluOp = op; id_func = fn;
    {id_regWrite, id_memRead, id_memWrite, id_memToReg,
     id_aluSrc, id_regDst, id_branch} = ctl;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd;
    #1;
    hz = m_ex.v && m_ex.ctl[5] && (m_ex.rt != 5'd0) && v &&
         ((m_ex.rt == rs) || (m_ex.rt == rt));
    exp_stall = hz && !fl;
    if (!rst) begin
      chk({tag, ".stall"}, {127'd0, stall}, {127'd0, exp_stall});
      chk({tag, ".pc_write"}, {127'd0, pc_write}, {127'd0, !exp_stall});
      chk({tag, ".ifid_write"}, {127'd0, ifid_write}, {127'd0, !exp_stall});
    end
    e.cnt  = m_cnt;
    e.cnt2 = m_cnt2;
    if (rst) begin
      e.ex = BUBBLE; e.cnt = 0; e.cnt2 = 0;
    end else if (fl) begin
      e.ex = BUBBLE;
    end else if (hz) begin
      e.ex = BUBBLE;
      if (e.cnt < 65535) e.cnt++;
      if (e.cnt2 < 3) e.cnt2++;
    end else if (!v) begin
      e.ex = BUBBLE;
    end else begin
      e.ex = '{v: 1'b1, op: op, fn: fn, ctl: ctl, rsd: rsd, rtd: rtd,
               imm: imm, rs: rs, rt: rt, rd: rd};
    end
    sbq.push_back(e);
    m_ex = e.ex; m_cnt = e.cnt; m_cnt2 = e.cnt2;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, ".sb_empty"}, 128'd0, 128'd1);
    end else begin
      got = sbq.pop_front();
      chk({tag, ".ex"}, {1'b0, obs_ex}, {1'b0, got.ex});
      chk({tag, ".count"}, {112'd0, stall_count}, 128'(got.cnt));
      chk({tag, ".count_sat"}, {126'd0, stall_count2}, 128'(got.cnt2));
    end
  endtask

  // Control patterns: {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, branch}
  localparam logic [6:0] C_R  = 7'b1000010;
  localparam logic [6:0] C_LW = 7'b1101100;
  localparam logic [6:0] C_SB = 7'b0000001;

  initial begin
    m_ex = BUBBLE; m_cnt = 0; m_cnt2 = 0;
    reset = 1'b1; flush = 1'b0; id_valid = 1'b0; id_aluOp = 2'b00; id_func = 6'd0;
    {id_regWrite, id_memRead, id_memWrite, id_memToReg,
     id_aluSrc, id_regDst, id_branch} = 7'd0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_rs = '0; id_rt = '0; id_rd = '0;

    // Reset for two cycles with random ID contents.
    for (int i = 0; i < 2; i++)
      step("reset", 1'b1, 1'($urandom), 1'b1, 2'($urandom_range(0, 2)), 6'($urandom),
           7'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
           5'($urandom));

    // Plain R-type add passes through.
    step("pass_add", 1'b0, 1'b0, 1'b1, 2'b00, 6'b100000, C_R, 32'd5, 32'd7,
         32'h0000_1234, 5'd8, 5'd9, 5'd10);
    // Empty ID slot becomes a bubble.
    step("id_invalid", 1'b0, 1'b0, 1'b0, 2'b00, 6'b100010, C_R, 32'd1, 32'd2,
         32'd3, 5'd1, 5'd2, 5'd3);
    // lw $9, 4($8), then dependent add $10 = $9 + $11: one bubble, then add.
    step("lw9", 1'b0, 1'b0, 1'b1, 2'b01, 6'd0, C_LW, 32'd100, 32'd0, 32'd4,
         5'd8, 5'd9, 5'd0);
    step("use9_stall", 1'b0, 1'b0, 1'b1, 2'b00, 6'b100000, C_R, 32'd55, 32'd66,
         32'd0, 5'd9, 5'd11, 5'd10);
    step("use9_go", 1'b0, 1'b0, 1'b1, 2'b00, 6'b100000, C_R, 32'd55, 32'd66,
         32'd0, 5'd9, 5'd11, 5'd10);
    // Load to $0 never stalls.
    step("lw0", 1'b0, 1'b0, 1'b1, 2'b01, 6'd0, C_LW, 32'd100, 32'd0, 32'd8,
         5'd8, 5'd0, 5'd0);
    step("use0", 1'b0, 1'b0, 1'b1, 2'b00, 6'b100000, C_R, 32'd0, 32'd0,
         32'd0, 5'd0, 5'd0, 5'd12);
    // Consumer via rt field also stalls.
    step("lw7", 1'b0, 1'b0, 1'b1, 2'b01, 6'd0, C_LW, 32'd20, 32'd0, 32'd0,
         5'd1, 5'd7, 5'd0);
    step("use7_rt", 1'b0, 1'b0, 1'b1, 2'b00, 6'b100010, C_R, 32'd1, 32'd2,
         32'd0, 5'd2, 5'd7, 5'd4);
    // Taken-branch flush squashes a valid sub.
    step("flush_sub", 1'b0, 1'b1, 1'b1, 2'b10, 6'd0, C_SB, 32'd9, 32'd9,
         32'hFFFF_FFFC, 5'd3, 5'd4, 5'd0);
    // Flush coincident with a hazard: flush wins, counter unchanged.
    step("lw3", 1'b0, 1'b0, 1'b1, 2'b01, 6'd0, C_LW, 32'd0, 32'd0, 32'd12,
         5'd2, 5'd3, 5'd0);
    step("flush_hz", 1'b0, 1'b1, 1'b1, 2'b00, 6'b100000, C_R, 32'd1, 32'd1,
         32'd0, 5'd3, 5'd5, 5'd6);
    // Repeated load-use pairs drive the 2-bit counter into saturation.
    for (int i = 0; i < 5; i++) begin
      step("sat_lw", 1'b0, 1'b0, 1'b1, 2'b01, 6'd0, C_LW, 32'(i), 32'd0, 32'd0,
           5'd1, 5'd5, 5'd0);
      step("sat_use", 1'b0, 1'b0, 1'b1, 2'b00, 6'b100101, C_R, 32'(i), 32'd3,
           32'd0, 5'd5, 5'd6, 5'd7);
    end
    // Back-to-back load into a dependent load: still exactly one bubble.
    step("lw_a", 1'b0, 1'b0, 1'b1, 2'b01, 6'd0, C_LW, 32'd1, 32'd0, 32'd0,
         5'd1, 5'd12, 5'd0);
    step("lw_b_stall", 1'b0, 1'b0, 1'b1, 2'b01, 6'd0, C_LW, 32'd2, 32'd0, 32'd4,
         5'd12, 5'd13, 5'd0);
    step("lw_b_go", 1'b0, 1'b0, 1'b1, 2'b01, 6'd0, C_LW, 32'd2, 32'd0, 32'd4,
         5'd12, 5'd13, 5'd0);
    // Reset mid-stream with a pending hazard and flush still yields a bubble.
    step("reset_mid", 1'b1, 1'b1, 1'b1, 2'b00, 6'b100000, C_R, 32'd1, 32'd2,
         32'd3, 5'd13, 5'd1, 5'd2);
    step("after_reset", 1'b0, 1'b0, 1'b1, 2'b00, 6'b101010, C_R, 32'hDEAD_BEEF,
         32'h0BAD_F00D, 32'd0, 5'd30, 5'd31, 5'd29);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined MIPS datapath. Registers the decoded instruction (control bits, ALU op class, funct field, operands, register indices) from ID, and drives the EX stage: the ALU control decoder consumes `ex_aluOp`/`ex_func` directly. Contains the load-use hazard detector, which inserts one bubble and freezes PC and IF/ID. Also handles squash on taken branch.

## Interface
Parameters:
- `DATA_W`, 32, operand/immediate width
- `REG_W`, 5, register index width
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  clock; one clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `id_valid`  in  1  ID holds a real instruction
- `id_aluOp`  in  2  00 R-type (use funct), 01 ADD class (addi/lw/sw), 10 SUB class (subi/branch/slti); 11 never issued
- `id_func`  in  6  funct field
- `id_regWrite`, `id_memRead`, `id_memWrite`, `id_memToReg`, `id_aluSrc`, `id_regDst`, `id_branch`  in  1 each  main-control bits
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read data
- `id_imm`  in  DATA_W  sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  REG_W  register indices
- `flush`  in  1  branch taken in MEM; squash ID
- `ex_valid`  out  1  EX holds a real instruction
- `ex_aluOp`  out  2, `ex_func`  out  6  to ALU control
- `ex_regWrite`, `ex_memRead`, `ex_memWrite`, `ex_memToReg`, `ex_aluSrc`, `ex_regDst`, `ex_branch`  out  1 each
- `ex_rs_data`, `ex_rt_data`, `ex_imm`  out  DATA_W
- `ex_rs`, `ex_rt`, `ex_rd`  out  REG_W
- `stall`  out  1  load-use hazard this cycle (combinational)
- `pc_write`, `ifid_write`  out  1  = ~stall
- `stall_count`  out  CNT_W  saturating count of inserted load-use bubbles

## Operation
- Bubble definition: `ex_valid`=0, all seven control bits 0, `ex_aluOp`=01, `ex_func`=000000, data/index outputs 0. aluOp 01 guarantees ALU control never sees an undecodable R-type funct.
- Reset value of every output register = bubble; `stall_count`=0.
- Hazard (combinational): `hz` = `ex_valid` & `ex_memRead` & (`ex_rt`≠0) & `id_valid` & (`ex_rt`==`id_rs` | `ex_rt`==`id_rt`). Both sources compared unconditionally (conservative for I-type).
- `stall` = `hz` & ~`flush`; `pc_write` = `ifid_write` = ~`stall`.
- Register update priority per rising edge:
  1. `reset`: load bubble, clear counter.
  2. `flush`: load bubble (ID instruction squashed); counter unchanged.
  3. `hz`: load bubble; counter += 1, saturating at 2^CNT_W−1.
  4. `id_valid`=0: load bubble.
  5. else: load all `id_*` fields, `ex_valid`=1.
- Stall lasts exactly one cycle: the bubble clears `ex_memRead`, so `hz` drops; the held ID instruction then enters EX.
- Back-to-back loads: each dependent consumer costs exactly one bubble.
- No internal FSM beyond the register contents; state = EX register + counter.

## Timing
- ID→EX latency: 1 cycle (fields on `id_*` at edge N appear on `ex_*` after edge N).
- `stall`, `pc_write`, `ifid_write`: combinational from current `ex_*` and `id_*`, valid same cycle, no register.
- `flush` and hazard in the same cycle: flush wins, `stall`=0, counter not incremented.
- `reset` asserted mid-stream: bubble on the next edge regardless of `flush`/`hz`; `stall` may be combinationally high during reset but is ignored upstream because upstream is in reset too.
- Counter saturates; never wraps.

## Test plan
- Reset: hold `reset` 2 cycles with random `id_*` → all ex outputs 0, `ex_aluOp`=01, `ex_func`=0, `stall_count`=0.
- Pass-through: `id_valid`=1, aluOp 00, func 100000, rs=8 data 5, rt=9 data 7 → next cycle identical values on `ex_*`, `ex_valid`=1, `stall`=0.
- Load-use: lw rt=9 in EX (`ex_memRead`=1), ID add rs=9 → `stall`=1, `pc_write`=0; next cycle EX bubble, `stall`=0, add enters EX following cycle; `stall_count`=1. Repeat with rt=0 → no stall.
- Flush: `flush`=1 with valid ID sub → EX bubble next cycle, `ex_regWrite`=0.
- Flush + hazard same cycle → `stall`=0, bubble loaded, `stall_count` unchanged.
- Saturation: CNT_W=2, force 5 load-use stalls → `stall_count` stays 3.
